lcd_pattern_gen: RTL and testbench

Synthesizable, parametrised test-pattern source for the LCD path: it scans an H_ACTIVE x V_ACTIVE raster and emits one RGB pixel per accepted transfer over a valid/ready stream. It supports checkerboard, colour-bar, gradient and solid modes, plus frame/line markers. It sits directly upstream of the LCD display sink and replaces hand-written behavioural pattern stimulus in benches and bring-up builds.

---
 rtl/lcd_pattern_gen.sv | 214 +++++++++++++++++++++
 tb/tb_lcd_pattern_gen.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_pattern_gen.sv
// LCD test-pattern source: scans an H_ACTIVE x V_ACTIVE raster and streams one RGB
// pixel per valid/ready transfer (checker, colour bars, gradient, solid).
module lcd_pattern_gen #(
    parameter int unsigned H_ACTIVE = 480,
    parameter int unsigned V_ACTIVE = 272,
    parameter int unsigned TILE     = 24,
    parameter int unsigned CW       = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [1:0]      mode,
    input  logic [3*CW-1:0] fg_rgb,
    input  logic [3*CW-1:0] bg_rgb,
    input  logic            ready,
    output logic            valid,
    output logic [9:0]      x,
    output logic [9:0]      y,
    output logic [CW-1:0]   r,
    output logic [CW-1:0]   g,
    output logic [CW-1:0]   b,
    output logic            sof,
    output logic            eol,
    output logic            eof,
    output logic [15:0]     frame_cnt
);

    localparam int unsigned XW     = 10;
    localparam int unsigned PW     = 3 * CW;
    localparam int unsigned BW_RAW = H_ACTIVE / 8;
    localparam int unsigned BW     = (BW_RAW == 0) ? 1 : BW_RAW;

    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [XW-1:0] Y_LAST = XW'(V_ACTIVE - 1);
    localparam logic [XW-1:0] T_LAST = XW'(TILE - 1);
    localparam logic [XW-1:0] B_LAST = XW'(BW - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state, state_n;
    logic [1:0]      mode_q, mode_n;
    logic [PW-1:0]   fg_q, fg_n, bg_q, bg_n;
    logic [XW-1:0]   x_n, y_n;
    logic [XW-1:0]   tx_cnt, tx_cnt_n, ty_cnt, ty_cnt_n, bx_cnt, bx_cnt_n;
    logic            tx_par, tx_par_n, ty_par, ty_par_n;
    logic [2:0]      bar_idx, bar_idx_n;
    logic            valid_n, sof_n, eol_n, eof_n;
    logic [15:0]     frame_cnt_n;
    logic [PW-1:0]   pix_q, pix_n;
    logic            start, stop, adv;
    logic [2:0]      code;
    logic [CW-1:0]   grad_b;

    assign {r, g, b} = pix_q;

    // Next-state, next-pixel position/counters and the colour of that next pixel.
    always_comb begin
        state_n     = state;
        mode_n      = mode_q;
        fg_n        = fg_q;
        bg_n        = bg_q;
        x_n         = x;
        y_n         = y;
        tx_cnt_n    = tx_cnt;
        ty_cnt_n    = ty_cnt;
        bx_cnt_n    = bx_cnt;
        tx_par_n    = tx_par;
        ty_par_n    = ty_par;
        bar_idx_n   = bar_idx;
        valid_n     = valid;
        frame_cnt_n = frame_cnt;
        start       = 1'b0;
        stop        = 1'b0;
        adv         = 1'b0;
        pix_n       = '0;
        code        = 3'd0;
        grad_b      = '0;

        case (state)
            IDLE: begin
                if (en) begin
                    state_n = RUN;
                    start   = 1'b1;
                end
            end
            RUN: begin
                if (valid && ready) begin
                    if (eof) begin
                        frame_cnt_n = frame_cnt + 16'd1;
                        if (en) begin
                            start = 1'b1;
                        end else begin
                            state_n = IDLE;
                            stop    = 1'b1;
                        end
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (start || stop) begin
            x_n       = '0;
            y_n       = '0;
            tx_cnt_n  = '0;
            ty_cnt_n  = '0;
            bx_cnt_n  = '0;
            tx_par_n  = 1'b0;
            ty_par_n  = 1'b0;
            bar_idx_n = 3'd0;
            valid_n   = start;
        end
        if (start) begin
            mode_n = mode;
            fg_n   = fg_rgb;
            bg_n   = bg_rgb;
        end

        // Mid-frame advance; the y wrap is covered by the eof branch above.
        if (adv) begin
            if (x == X_LAST) begin
                x_n       = '0;
                y_n       = y + 10'd1;
                tx_cnt_n  = '0;
                tx_par_n  = 1'b0;
                bx_cnt_n  = '0;
                bar_idx_n = 3'd0;
                if (ty_cnt == T_LAST) begin
                    ty_cnt_n = '0;
                    ty_par_n = ~ty_par;
                end else begin
                    ty_cnt_n = ty_cnt + 10'd1;
                end
            end else begin
                x_n = x + 10'd1;
                if (tx_cnt == T_LAST) begin
                    tx_cnt_n = '0;
                    tx_par_n = ~tx_par;
                end else begin
                    tx_cnt_n = tx_cnt + 10'd1;
                end
                if (bx_cnt == B_LAST) begin
                    bx_cnt_n = '0;
                    if (bar_idx != 3'd7) begin
                        bar_idx_n = bar_idx + 3'd1;
                    end
                end else begin
                    bx_cnt_n = bx_cnt + 10'd1;
                end
            end
        end

        code   = 3'd7 - bar_idx_n;
        grad_b = CW'(x_n + y_n);
        if (valid_n) begin
            case (mode_n)
                2'd0:    pix_n = (tx_par_n ^ ty_par_n) ? bg_n : fg_n;
                2'd1:    pix_n = {{CW{code[2]}}, {CW{code[1]}}, {CW{code[0]}}};
                2'd2:    pix_n = {x_n[CW-1:0], y_n[CW-1:0], grad_b};
                default: pix_n = fg_n;
            endcase
        end

        sof_n = valid_n && (x_n == '0) && (y_n == '0);
        eol_n = valid_n && (x_n == X_LAST);
        eof_n = eol_n && (y_n == Y_LAST);
    end

    // State and all output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mode_q    <= 2'd0;
            fg_q      <= '0;
            bg_q      <= '0;
            x         <= '0;
            y         <= '0;
            tx_cnt    <= '0;
            ty_cnt    <= '0;
            bx_cnt    <= '0;
            tx_par    <= 1'b0;
            ty_par    <= 1'b0;
            bar_idx   <= 3'd0;
            valid     <= 1'b0;
            sof       <= 1'b0;
            eol       <= 1'b0;
            eof       <= 1'b0;
            frame_cnt <= 16'd0;
            pix_q     <= '0;
        end else begin
            state     <= state_n;
            mode_q    <= mode_n;
            fg_q      <= fg_n;
            bg_q      <= bg_n;
            x         <= x_n;
            y         <= y_n;
            tx_cnt    <= tx_cnt_n;
            ty_cnt    <= ty_cnt_n;
            bx_cnt    <= bx_cnt_n;
            tx_par    <= tx_par_n;
            ty_par    <= ty_par_n;
            bar_idx   <= bar_idx_n;
            valid     <= valid_n;
            sof       <= sof_n;
            eol       <= eol_n;
            eof       <= eof_n;
            frame_cnt <= frame_cnt_n;
            pix_q     <= pix_n;
        end
    end

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Directed bench for lcd_pattern_gen on a small 17x4 raster with 3-pixel tiles and 4-bit colour.
module tb_lcd_pattern_gen;

    localparam int H    = 17;
    localparam int V    = 4;
    localparam int TL   = 3;
    localparam int CWID = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [1:0]      mode;
    logic [11:0]     fg_rgb, bg_rgb;
    logic            ready;
    logic            valid;
    logic [9:0]      x, y;
    logic [3:0]      r, g, b;
    logic            sof, eol, eof;
    logic [15:0]     frame_cnt;

    lcd_pattern_gen #(.H_ACTIVE(H), .V_ACTIVE(V), .TILE(TL), .CW(CWID)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .fg_rgb(fg_rgb), .bg_rgb(bg_rgb),
        .ready(ready), .valid(valid), .x(x), .y(y), .r(r), .g(g), .b(b),
        .sof(sof), .eol(eol), .eof(eof), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Hand-computed pixels: fg=900, bg=003, bars BW=2, gradient truncated to 4 bits.
    typedef struct { logic [1:0] m; int sx; int sy; logic [11:0] rgb; } spot_t;
    spot_t spots [16];

    // Reference model state
    bit          m_run;
    int          mx, my, m_xfers;
    logic [15:0] m_fc;
    logic [1:0]  m_mode;
    logic [11:0] m_fg, m_bg;

    function automatic logic [11:0] exp_pix(input logic [1:0] m, input logic [11:0] f,
                                            input logic [11:0] bk, input int px, input int py);
        int idx;
        logic [2:0] code;
        case (m)
            2'd0: return ((((px / TL) ^ (py / TL)) & 1) != 0) ? bk : f;
            2'd1: begin
                idx = px / (H / 8);
                if (idx > 7) idx = 7;
                code = 3'(7 - idx);
                return {{4{code[2]}}, {4{code[1]}}, {4{code[0]}}};
            end
            2'd2: return {4'(px), 4'(py), 4'(px + py)};
            default: return f;
        endcase
    endfunction

    task automatic latch_model();
        m_mode = mode;
        m_fg   = fg_rgb;
        m_bg   = bg_rgb;
        mx     = 0;
        my     = 0;
    endtask

    task automatic model_edge();
        if (!m_run) begin
            if (en) begin
                m_run = 1'b1;
                latch_model();
            end
        end else if (ready) begin
            m_xfers++;
            if (mx == H - 1 && my == V - 1) begin
                check("frame_len", 64'(m_xfers), 64'(H * V));
                m_xfers = 0;
                m_fc++;
                if (en) latch_model();
                else m_run = 1'b0;
            end else if (mx == H - 1) begin
                mx = 0;
                my++;
            end else begin
                mx++;
            end
        end
    endtask

    task automatic compare();
        logic [35:0] got, exp;
        got = {valid, x, y, r, g, b, sof, eol, eof};
        if (m_run) begin
            exp = {1'b1, 10'(mx), 10'(my), exp_pix(m_mode, m_fg, m_bg, mx, my),
                   1'(mx == 0 && my == 0), 1'(mx == H - 1), 1'(mx == H - 1 && my == V - 1)};
            check("pix", 64'(got), 64'(exp));
            foreach (spots[i])
                if (spots[i].m == m_mode && spots[i].sx == mx && spots[i].sy == my)
                    check("spot", 64'({r, g, b}), 64'(spots[i].rgb));
        end else begin
            check("valid_low", 64'(valid), 64'd0);
        end
        check("fcnt", 64'(frame_cnt), 64'(m_fc));
    endtask

    task automatic step(input logic rdy);
        ready = rdy;
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    initial begin
        int n;
        spots[0]  = '{2'd0, 0, 0, 12'h900};
        spots[1]  = '{2'd0, 2, 0, 12'h900};
        spots[2]  = '{2'd0, 3, 0, 12'h003};
        spots[3]  = '{2'd0, 3, 3, 12'h900};
        spots[4]  = '{2'd0, 15, 0, 12'h003};
        spots[5]  = '{2'd0, 16, 3, 12'h900};
        spots[6]  = '{2'd0, 0, 3, 12'h003};
        spots[7]  = '{2'd1, 0, 1, 12'hFFF};
        spots[8]  = '{2'd1, 2, 1, 12'hFF0};
        spots[9]  = '{2'd1, 13, 1, 12'h00F};
        spots[10] = '{2'd1, 14, 1, 12'h000};
        spots[11] = '{2'd1, 16, 1, 12'h000};
        spots[12] = '{2'd2, 5, 2, 12'h527};
        spots[13] = '{2'd2, 16, 3, 12'h033};
        spots[14] = '{2'd2, 9, 3, 12'h93C};
        spots[15] = '{2'd3, 7, 1, 12'h900};

        rst = 1'b1; en = 1'b0; mode = 2'd0; ready = 1'b0;
        fg_rgb = 12'h900; bg_rgb = 12'h003;
        m_run = 1'b0; mx = 0; my = 0; m_xfers = 0; m_fc = 16'd0;
        m_mode = 2'd0; m_fg = '0; m_bg = '0;
        repeat (3) @(negedge clk);
        check("rst_out", 64'({valid, x, y, r, g, b, sof, eol, eof}), 64'd0);
        check("rst_fcnt", 64'(frame_cnt), 64'd0);
        rst = 1'b0;

        // Checker frame with a mid-frame mode change, then a colour-bar frame.
        en = 1'b1;
        repeat (30) step(1'b1);
        mode = 2'd1;
        repeat (39) step(1'b1);
        check("fc_one", 64'(frame_cnt), 64'd1);
        check("bars_first", 64'({r, g, b}), 64'hFFF);
        mode = 2'd2;
        repeat (H * V) step(1'b1);

        // Gradient under random back-pressure; solid mode queued for the next frame.
        mode = 2'd3;
        n = 0;
        while (m_fc < 3 && n < 600) begin
            step(1'($urandom_range(0, 1)));
            n++;
        end
        if (m_fc < 3) check("timeout_grad", 64'd0, 64'd1);

        // Solid frame, en dropped mid-frame: frame must complete then go idle.
        repeat (20) step(1'b1);
        en = 1'b0;
        n = 0;
        while (m_run && n < 100) begin
            step(1'b1);
            n++;
        end
        if (m_run) check("timeout_stop", 64'd0, 64'd1);
        repeat (3) step(1'b1);
        check("idle_valid", 64'(valid), 64'd0);
        check("fc_four", 64'(frame_cnt), 64'd4);

        // Asynchronous reset in the middle of a checker frame.
        en = 1'b1; mode = 2'd0;
        n = 0;
        while (!(m_run && mx == 10 && my == 2) && n < 100) begin
            step(1'b1);
            n++;
        end
        if (!(m_run && mx == 10 && my == 2)) check("timeout_pos", 64'd0, 64'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_async", 64'({valid, x, y, r, g, b, sof, eol, eof}), 64'd0);
        check("rst_async_fcnt", 64'(frame_cnt), 64'd0);
        m_run = 1'b0; m_fc = 16'd0; m_xfers = 0;
        @(negedge clk);
        rst = 1'b0;
        step(1'b1);
        check("restart_sof", 64'({valid, x, y, sof}), {43'd0, 1'b1, 20'd0, 1'b1} >> 0);
        repeat (5) step(1'b1);

        // Finish the frame, preload frame_cnt and check the wrap to zero.
        en = 1'b0;
        n = 0;
        while (m_run && n < 100) begin
            step(1'b1);
            n++;
        end
        if (m_run) check("timeout_idle", 64'd0, 64'd1);
        force dut.frame_cnt = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.frame_cnt;
        m_fc = 16'hFFFF;
        step(1'b0);
        en = 1'b1;
        n = 0;
        while (m_fc != 16'd0 && n < 100) begin
            step(1'b1);
            n++;
        end
        check("fc_wrap", 64'(frame_cnt), 64'd0);
        repeat (3) step(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
